// File: rtl/mdio_rd_completer.sv
// mdio_rd_completer
//   Watches the TRN receive stream for 32-bit memory reads that hit BAR0 and
//   answers each one with a single-DW completion on the TRN transmit port.
//   The payload is either the latest MDIO read result (byte-swapped into
//   TLP byte order) or the MDIO busy flag. Any other dword reads as zero.
//   A read with length other than 1 is answered with an Unsupported Request.
// Ports
//   trn_clk, reset_n          : PCIe user clock, async active-low reset
//   trn_rd, trn_r*_n          : RX stream (observed only, never back-pressured)
//   trn_td, trn_t*_n          : TX stream, owned only while a completion is in flight
//   cfg_completer_id          : bus/dev/func placed in the completion header
//   mdio_rd_data, mdio_busy   : MDIO status, already in the trn_clk domain
//   compl_busy                : a completion is latched and not yet fully accepted
//   rd_drop                   : one-cycle pulse when a read is discarded while busy
module mdio_rd_completer #(
  parameter bit CPL_TC_FROM_REQ = 1'b1
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tdst_dsc_n,
  input  logic [15:0] cfg_completer_id,
  input  logic [31:0] mdio_rd_data,
  input  logic        mdio_busy,
  output logic        compl_busy,
  output logic        rd_drop
);

  typedef enum logic {R_IDLE, R_HDR1} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_QW0, T_QW1} tx_state_t;

  // Completion byte count derived from the first-DW byte enables.
  function automatic logic [11:0] fbe_byte_count(input logic [3:0] fbe);
    casez (fbe)
      4'b1??1:                     fbe_byte_count = 12'd4;
      4'b01?1, 4'b1?10:            fbe_byte_count = 12'd3;
      4'b0011, 4'b0110, 4'b1100:   fbe_byte_count = 12'd2;
      default:                     fbe_byte_count = 12'd1;
    endcase
  endfunction

  // Index of the lowest enabled byte; zero when no byte is enabled.
  function automatic logic [1:0] fbe_lowest(input logic [3:0] fbe);
    if (fbe[0])      fbe_lowest = 2'd0;
    else if (fbe[1]) fbe_lowest = 2'd1;
    else if (fbe[2]) fbe_lowest = 2'd2;
    else if (fbe[3]) fbe_lowest = 2'd3;
    else             fbe_lowest = 2'd0;
  endfunction

  rx_state_t   rx_state_r, rx_state_nxt_s;
  tx_state_t   tx_state_r, tx_state_nxt_s;

  logic [9:0]  len_r;
  logic [2:0]  tc_r;
  logic [1:0]  attr_r;
  logic [15:0] req_id_r;
  logic [7:0]  tag_r;
  logic [3:0]  fbe_r;
  logic [63:0] qw1_r;
  logic        cpld_r;

  logic [63:0] td_r, td_nxt_s;
  logic [7:0]  trem_n_r, trem_n_nxt_s;
  logic        tsof_n_r, tsof_n_nxt_s;
  logic        teof_n_r, teof_n_nxt_s;
  logic        tsrc_rdy_n_r, tsrc_rdy_n_nxt_s;
  logic        tsrc_dsc_n_r;
  logic        compl_busy_r, compl_busy_nxt_s;
  logic        rd_drop_r, rd_drop_nxt_s;

  logic        rx_beat_s, hdr_cap_s, rsp_cap_s;
  logic        cpld_s;
  logic [31:0] addr_s, payload_s;
  logic [11:0] bc_s;
  logic [63:0] qw0_s, qw1_s;
  logic        unused_s;

  // Only part of the RX data and none of the RX end-of-frame are needed.
  assign unused_s  = ^{trn_reof_n, trn_rd};
  assign rx_beat_s = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign addr_s    = trn_rd[63:32];

  // Build both completion qwords from the captured request and live MDIO state.
  always_comb begin
    cpld_s    = (len_r == 10'd1);
    payload_s = 32'h0000_0000;
    case (addr_s[5:2])
      4'b0100: payload_s = {mdio_rd_data[7:0], mdio_rd_data[15:8],
                            mdio_rd_data[23:16], mdio_rd_data[31:24]};
      4'b0101: payload_s = {31'd0, mdio_busy};
      default: payload_s = 32'h0000_0000;
    endcase
    bc_s  = cpld_s ? fbe_byte_count(fbe_r) : 12'd4;
    qw0_s = {1'b0, (cpld_s ? 7'b10_01010 : 7'b00_01010), 1'b0,
             (CPL_TC_FROM_REQ ? tc_r : 3'b000), 6'd0,
             (CPL_TC_FROM_REQ ? attr_r : 2'b00), 2'd0,
             (cpld_s ? 10'd1 : 10'd0),
             cfg_completer_id, (cpld_s ? 3'b000 : 3'b001), 1'b0, bc_s};
    qw1_s = {req_id_r, tag_r, 1'b0, addr_s[6:2], fbe_lowest(fbe_r),
             (cpld_s ? payload_s : 32'h0000_0000)};
  end

  // Next-state and next-output logic for both the RX sniffer and TX sender.
  always_comb begin
    rx_state_nxt_s   = rx_state_r;
    tx_state_nxt_s   = tx_state_r;
    hdr_cap_s        = 1'b0;
    rsp_cap_s        = 1'b0;
    rd_drop_nxt_s    = 1'b0;
    td_nxt_s         = td_r;
    trem_n_nxt_s     = trem_n_r;
    tsof_n_nxt_s     = tsof_n_r;
    teof_n_nxt_s     = teof_n_r;
    tsrc_rdy_n_nxt_s = tsrc_rdy_n_r;
    compl_busy_nxt_s = compl_busy_r;

    case (rx_state_r)
      R_IDLE: begin
        if (rx_beat_s && !trn_rsof_n && !trn_rbar_hit_n[0] && (trn_rd[62:56] == 7'b00_00000)) begin
          rx_state_nxt_s = R_HDR1;
          hdr_cap_s      = 1'b1;
        end else begin
          rx_state_nxt_s = R_IDLE;
        end
      end
      R_HDR1: begin
        if (rx_beat_s) begin
          rx_state_nxt_s = R_IDLE;
          // compl_busy is still set in the cycle the previous last beat is taken.
          if (!compl_busy_r) begin
            rsp_cap_s = 1'b1;
          end else begin
            rd_drop_nxt_s = 1'b1;
          end
        end else begin
          rx_state_nxt_s = R_HDR1;
        end
      end
      default: rx_state_nxt_s = R_IDLE;
    endcase

    case (tx_state_r)
      T_IDLE: begin
        if (rsp_cap_s) begin
          tx_state_nxt_s   = T_QW0;
          td_nxt_s         = qw0_s;
          trem_n_nxt_s     = 8'h00;
          tsof_n_nxt_s     = 1'b0;
          teof_n_nxt_s     = 1'b1;
          tsrc_rdy_n_nxt_s = 1'b0;
          compl_busy_nxt_s = 1'b1;
        end else begin
          tx_state_nxt_s   = T_IDLE;
        end
      end
      T_QW0, T_QW1: begin
        if (!trn_tdst_dsc_n || (!trn_tdst_rdy_n && tx_state_r == T_QW1)) begin
          tx_state_nxt_s   = T_IDLE;
          td_nxt_s         = 64'd0;
          trem_n_nxt_s     = 8'h00;
          tsof_n_nxt_s     = 1'b1;
          teof_n_nxt_s     = 1'b1;
          tsrc_rdy_n_nxt_s = 1'b1;
          compl_busy_nxt_s = 1'b0;
        end else if (!trn_tdst_rdy_n) begin
          tx_state_nxt_s   = T_QW1;
          td_nxt_s         = qw1_r;
          trem_n_nxt_s     = cpld_r ? 8'h00 : 8'h0F;
          tsof_n_nxt_s     = 1'b1;
          teof_n_nxt_s     = 1'b0;
        end else begin
          tx_state_nxt_s   = tx_state_r;
        end
      end
      default: tx_state_nxt_s = T_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r   <= R_IDLE;
      tx_state_r   <= T_IDLE;
      td_r         <= 64'd0;
      trem_n_r     <= 8'h00;
      tsof_n_r     <= 1'b1;
      teof_n_r     <= 1'b1;
      tsrc_rdy_n_r <= 1'b1;
      tsrc_dsc_n_r <= 1'b1;
      compl_busy_r <= 1'b0;
      rd_drop_r    <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_nxt_s;
      tx_state_r   <= tx_state_nxt_s;
      td_r         <= td_nxt_s;
      trem_n_r     <= trem_n_nxt_s;
      tsof_n_r     <= tsof_n_nxt_s;
      teof_n_r     <= teof_n_nxt_s;
      tsrc_rdy_n_r <= tsrc_rdy_n_nxt_s;
      tsrc_dsc_n_r <= 1'b1;
      compl_busy_r <= compl_busy_nxt_s;
      rd_drop_r    <= rd_drop_nxt_s;
    end
  end

  // Request header fields and the pending second completion qword.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      len_r    <= 10'd0;
      tc_r     <= 3'd0;
      attr_r   <= 2'd0;
      req_id_r <= 16'd0;
      tag_r    <= 8'd0;
      fbe_r    <= 4'd0;
      qw1_r    <= 64'd0;
      cpld_r   <= 1'b0;
    end else begin
      if (hdr_cap_s) begin
        len_r    <= trn_rd[41:32];
        tc_r     <= trn_rd[54:52];
        attr_r   <= trn_rd[45:44];
        req_id_r <= trn_rd[31:16];
        tag_r    <= trn_rd[15:8];
        fbe_r    <= trn_rd[3:0];
      end
      if (rsp_cap_s) begin
        qw1_r  <= qw1_s;
        cpld_r <= cpld_s;
      end
    end
  end

  assign trn_td         = td_r;
  assign trn_trem_n     = trem_n_r;
  assign trn_tsof_n     = tsof_n_r;
  assign trn_teof_n     = teof_n_r;
  assign trn_tsrc_rdy_n = tsrc_rdy_n_r;
  assign trn_tsrc_dsc_n = tsrc_dsc_n_r;
  assign compl_busy     = compl_busy_r;
  assign rd_drop        = rd_drop_r;

endmodule

// File: tb/tb_mdio_rd_completer.sv
// Directed bench for mdio_rd_completer: drives MemRd32 headers on the RX
// stream and checks each completion beat against hand-computed qwords.
module tb_mdio_rd_completer;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic [63:0] trn_rd;
  logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n, trn_tdst_dsc_n;
  logic [15:0] cfg_completer_id;
  logic [31:0] mdio_rd_data;
  logic        mdio_busy;
  logic        compl_busy, rd_drop;

  int total = 0;
  int bad = 0;
  int sof_cnt = 0;
  int drop_cnt = 0;
  int sof_base;
  int drop_base;

  mdio_rd_completer #(.CPL_TC_FROM_REQ(1'b1)) dut (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_tdst_dsc_n(trn_tdst_dsc_n), .cfg_completer_id(cfg_completer_id),
    .mdio_rd_data(mdio_rd_data), .mdio_busy(mdio_busy),
    .compl_busy(compl_busy), .rd_drop(rd_drop)
  );

  always #5 trn_clk = ~trn_clk;

  // Count accepted start-of-frame beats and drop pulses, sampled mid-cycle.
  always @(negedge trn_clk) begin
    if (!trn_tsof_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) sof_cnt++;
    if (rd_drop) drop_cnt++;
  end

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Two header beats; returns one cycle after the second beat is accepted.
  task automatic send_rd(input logic [6:0] bar_n, input logic [31:0] hi,
                         input logic [31:0] lo, input logic [31:0] addr);
    trn_rbar_hit_n = bar_n;
    trn_rsof_n     = 1'b0;
    trn_rsrc_rdy_n = 1'b0;
    trn_rd         = {hi, lo};
    step();
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b0;
    trn_rd         = {addr, 32'h0};
    step();
    trn_rsrc_rdy_n = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rd         = 64'd0;
    trn_rbar_hit_n = 7'h7F;
  endtask

  // Called in the first completion cycle with the sink ready.
  task automatic cpl_check(input string tag, input logic [63:0] qw0,
                           input logic [63:0] qw1, input logic [7:0] trem);
    chk({tag, "_busy"}, {63'd0, compl_busy}, 64'd1);
    chk({tag, "_sof"},  {63'd0, trn_tsof_n}, 64'd0);
    chk({tag, "_rdy0"}, {63'd0, trn_tsrc_rdy_n}, 64'd0);
    chk({tag, "_qw0"},  trn_td, qw0);
    step();
    chk({tag, "_eof"},  {63'd0, trn_teof_n}, 64'd0);
    chk({tag, "_sof1"}, {63'd0, trn_tsof_n}, 64'd1);
    chk({tag, "_qw1"},  trn_td, qw1);
    chk({tag, "_trem"}, {56'd0, trn_trem_n}, {56'd0, trem});
    step();
    chk({tag, "_rdy_idle"},  {63'd0, trn_tsrc_rdy_n}, 64'd1);
    chk({tag, "_busy_idle"}, {63'd0, compl_busy}, 64'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    trn_rd           = 64'd0;
    trn_rsof_n       = 1'b1;
    trn_reof_n       = 1'b1;
    trn_rsrc_rdy_n   = 1'b1;
    trn_rdst_rdy_n   = 1'b0;
    trn_rbar_hit_n   = 7'h7F;
    trn_tdst_rdy_n   = 1'b0;
    trn_tdst_dsc_n   = 1'b1;
    cfg_completer_id = 16'hBEEF;
    mdio_rd_data     = 32'h1122_3344;
    mdio_busy        = 1'b0;
    step();
    step();
    chk("rst_td",   trn_td, 64'd0);
    chk("rst_trem", {56'd0, trn_trem_n}, 64'd0);
    chk("rst_frm",  {60'd0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 64'hF);
    chk("rst_busy", {62'd0, compl_busy, rd_drop}, 64'd0);
    reset_n = 1'b1;
    step();

    // Mdio data, byte swapped.
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_2A0F, 32'h0000_0010);
    cpl_check("cpld_data", 64'h4A00_0001_BEEF_0004, 64'h0100_2A10_4433_2211, 8'h00);

    // Busy status dword, TC/attr copied from request.
    mdio_busy = 1'b1;
    send_rd(7'h7E, 32'h0050_2001, 32'h0100_2B0F, 32'h0000_0014);
    cpl_check("cpld_busy", 64'h4A50_2001_BEEF_0004, 64'h0100_2B14_0000_0001, 8'h00);

    // Unmapped dword.
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_2C0F, 32'h0000_0018);
    cpl_check("cpld_zero", 64'h4A00_0001_BEEF_0004, 64'h0100_2C18_0000_0000, 8'h00);
    mdio_busy = 1'b0;

    // Length 2 gets an Unsupported Request without data.
    send_rd(7'h7E, 32'h0000_0002, 32'h0100_300F, 32'h0000_0010);
    cpl_check("cpl_ur", 64'h0A00_0000_BEEF_2004, 64'h0100_3010_0000_0000, 8'h0F);

    // First BE 0110: two bytes starting at byte 1.
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_3106, 32'h0000_0010);
    cpl_check("fbe_0110", 64'h4A00_0001_BEEF_0002, 64'h0100_3111_4433_2211, 8'h00);

    // First BE 0000: byte count 1.
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_3200, 32'h0000_0018);
    cpl_check("fbe_0000", 64'h4A00_0001_BEEF_0001, 64'h0100_3218_0000_0000, 8'h00);

    // Sink stalled in QW0 while a second read arrives and is dropped.
    sof_base       = sof_cnt;
    drop_base      = drop_cnt;
    trn_tdst_rdy_n = 1'b1;
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_400F, 32'h0000_0010);
    chk("stall_qw0_a", trn_td, 64'h4A00_0001_BEEF_0004);
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_410F, 32'h0000_0014);
    chk("stall_qw0_b", trn_td, 64'h4A00_0001_BEEF_0004);
    chk("stall_sof_b", {63'd0, trn_tsof_n}, 64'd0);
    step();
    chk("stall_qw0_c", trn_td, 64'h4A00_0001_BEEF_0004);
    step();
    chk("stall_qw0_d", trn_td, 64'h4A00_0001_BEEF_0004);
    trn_tdst_rdy_n = 1'b0;
    cpl_check("stall_cpl", 64'h4A00_0001_BEEF_0004, 64'h0100_4010_4433_2211, 8'h00);
    step();
    step();
    chk("stall_one_cpl", sof_cnt - sof_base, 64'd1);
    chk("stall_one_drop", drop_cnt - drop_base, 64'd1);
    chk("stall_idle", {63'd0, trn_tsrc_rdy_n}, 64'd1);

    // Asynchronous reset while QW1 is on the bus.
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_500F, 32'h0000_0010);
    step();
    chk("pre_rst_eof", {63'd0, trn_teof_n}, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_frm", {60'd0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 64'hF);
    chk("mid_rst_busy", {63'd0, compl_busy}, 64'd0);
    chk("mid_rst_td", trn_td, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    send_rd(7'h7E, 32'h0000_0001, 32'h0100_510F, 32'h0000_0010);
    cpl_check("post_rst", 64'h4A00_0001_BEEF_0004, 64'h0100_5110_4433_2211, 8'h00);

    // Non-BAR0 read and a BAR0 MemWr32 produce nothing.
    sof_base = sof_cnt;
    send_rd(7'h7D, 32'h0000_0001, 32'h0100_600F, 32'h0000_0010);
    chk("nobar_busy", {63'd0, compl_busy}, 64'd0);
    chk("nobar_rdy",  {63'd0, trn_tsrc_rdy_n}, 64'd1);
    send_rd(7'h7E, 32'h4000_0001, 32'h0100_610F, 32'h0000_0010);
    chk("memwr_busy", {63'd0, compl_busy}, 64'd0);
    step();
    step();
    chk("ignored_no_sof", sof_cnt - sof_base, 64'd0);
    chk("dsc_held", {63'd0, trn_tsrc_dsc_n}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
